// File: rtl/spi_initiator_pkg.sv
// Shared types for the SPI initiator: FSM state encoding and the per-word mode
// captured when a command is accepted.
package spi_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic last;
  } spi_mode_t;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider for the SPI initiator: ticks every H = div+1 cycles, drives
// sck and flags leading/trailing edges while the FSM is shifting.
module spi_sck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] start_div,
  input  logic             run,
  input  logic             park,
  input  logic             park_lvl,
  input  logic             shift,
  input  logic             cpol,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             sck
);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;
  logic             sck_r;
  logic             tick_s;

  assign tick_s = (cnt_r == {DIV_W{1'b0}});

  // Reload at each terminal count so every FSM state lasts exactly H cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
      cnt_r <= {DIV_W{1'b0}};
      sck_r <= 1'b0;
    end else begin
      if (start) begin
        div_r <= start_div;
        cnt_r <= start_div;
      end else if (run) begin
        cnt_r <= tick_s ? div_r : cnt_r - DIV_W'(1);
      end
      if (park) begin
        sck_r <= park_lvl;
      end else if (shift && tick_s) begin
        sck_r <= ~sck_r;
      end
    end
  end

  assign tick  = tick_s;
  assign lead  = shift && tick_s && (sck_r == cpol);
  assign trail = shift && tick_s && (sck_r != cpol);
  assign sck   = sck_r;

endmodule

// File: rtl/spi_initiator_ctrl.sv
// SPI initiator with per-command mode, target select and CS hold between words.
// Define SPI_INITIATOR_CTRL_LSB_FIRST_EN to add the cmd_lsb_first input.
module spi_initiator_ctrl
  import spi_initiator_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CS_W-1:0]   cmd_cs,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  input  logic              cmd_last,
`ifdef SPI_INITIATOR_CTRL_LSB_FIRST_EN
  input  logic              cmd_lsb_first,
`endif
  input  logic [DIV_W-1:0]  clk_div,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sck,
  output logic              sdo,
  input  logic              sdi,
  output logic [NUM_CS-1:0] csn,
  output logic              busy
);

  localparam int TW = $clog2(2 * DATA_W);
  localparam logic [TW-1:0] LAST_TOG = TW'(2 * DATA_W - 1);

  spi_state_t        state_r, state_nxt;
  spi_mode_t         mode_r;
  logic [DATA_W-1:0] tx_r, rx_r, rsp_data_r, tx_src_s;
  logic [CS_W-1:0]   cs_r, cs_src_s;
  logic [NUM_CS-1:0] csn_r;
  logic [TW-1:0]     tog_r;
  logic held_r, lsb_r, sdo_r, rsp_valid_r;
  logic accept_s, need_gap_s, setup_enter_s, done_s, lsb_in_s, lsb_src_s;
  logic tick_s, lead_s, trail_s, shift_ev_s, sample_s, park_lvl_s;

`ifdef SPI_INITIATOR_CTRL_LSB_FIRST_EN
  assign lsb_in_s = cmd_lsb_first;
`else
  assign lsb_in_s = 1'b0;
`endif

  // Out-of-range selects decode to all-high so the word runs with no target.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] cs);
    logic [NUM_CS-1:0] v;
    v = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign accept_s      = cmd_valid && (state_r == ST_IDLE);
  assign need_gap_s    = held_r && (cmd_cs != cs_r);
  assign setup_enter_s = (accept_s && !need_gap_s) || ((state_r == ST_GAP) && tick_s);
  assign done_s        = (state_r == ST_HOLD) && tick_s;
  assign tx_src_s      = accept_s ? cmd_data : tx_r;
  assign cs_src_s      = accept_s ? cmd_cs : cs_r;
  assign lsb_src_s     = accept_s ? lsb_in_s : lsb_r;
  assign park_lvl_s    = accept_s ? cmd_cpol : mode_r.cpol;
  // CPHA=1 already presents the first bit in SETUP, so its first leading edge does not shift.
  assign shift_ev_s    = mode_r.cpha ? (lead_s && (tog_r != {TW{1'b0}})) : trail_s;
  assign sample_s      = mode_r.cpha ? trail_s : lead_s;

  spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept_s),
    .start_div (clk_div),
    .run       (state_r != ST_IDLE),
    .park      (setup_enter_s),
    .park_lvl  (park_lvl_s),
    .shift     (state_r == ST_SHIFT),
    .cpol      (mode_r.cpol),
    .tick      (tick_s),
    .lead      (lead_s),
    .trail     (trail_s),
    .sck       (sck)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:  if (cmd_valid) state_nxt = need_gap_s ? ST_GAP : ST_SETUP;
                else state_nxt = ST_IDLE;
      ST_GAP:   if (tick_s) state_nxt = ST_SETUP; else state_nxt = ST_GAP;
      ST_SETUP: if (tick_s) state_nxt = ST_SHIFT; else state_nxt = ST_SETUP;
      ST_SHIFT: if (tick_s && (tog_r == LAST_TOG)) state_nxt = ST_HOLD;
                else state_nxt = ST_SHIFT;
      ST_HOLD:  if (tick_s) state_nxt = ST_IDLE; else state_nxt = ST_HOLD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake/status outputs.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      default: begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Command capture, shift/sample datapath, chip selects and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= '{cpol: 1'b0, cpha: 1'b0, last: 1'b0};
      tx_r        <= {DATA_W{1'b0}};
      rx_r        <= {DATA_W{1'b0}};
      rsp_data_r  <= {DATA_W{1'b0}};
      cs_r        <= {CS_W{1'b0}};
      csn_r       <= {NUM_CS{1'b1}};
      tog_r       <= {TW{1'b0}};
      held_r      <= 1'b0;
      lsb_r       <= 1'b0;
      sdo_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      if (accept_s) begin
        mode_r <= '{cpol: cmd_cpol, cpha: cmd_cpha, last: cmd_last};
        tx_r   <= cmd_data;
        rx_r   <= {DATA_W{1'b0}};
        cs_r   <= cmd_cs;
        lsb_r  <= lsb_in_s;
        tog_r  <= {TW{1'b0}};
        if (need_gap_s) csn_r <= {NUM_CS{1'b1}};
      end
      if (setup_enter_s) begin
        csn_r <= cs_decode(cs_src_s);
        sdo_r <= lsb_src_s ? tx_src_s[0] : tx_src_s[DATA_W-1];
      end
      if ((state_r == ST_SHIFT) && tick_s) tog_r <= tog_r + TW'(1);
      if (shift_ev_s) begin
        tx_r  <= lsb_r ? {1'b0, tx_r[DATA_W-1:1]} : {tx_r[DATA_W-2:0], 1'b0};
        sdo_r <= lsb_r ? tx_r[1] : tx_r[DATA_W-2];
      end
      if (sample_s) begin
        rx_r <= lsb_r ? {sdi, rx_r[DATA_W-1:1]} : {rx_r[DATA_W-2:0], sdi};
      end
      if (done_s) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= rx_r;
        held_r      <= !mode_r.last;
        if (mode_r.last) csn_r <= {NUM_CS{1'b1}};
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign sdo       = sdo_r;
  assign csn       = csn_r;

endmodule

// File: doc/spi_initiator_ctrl.md
SPI_INITIATOR_CTRL -- requirements
Module: spi_initiator_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per transfer (>=2).
REQ-002 SHALL have parameter NUM_CS, default 4, number of chip selects (1..16).
REQ-003 SHALL have parameter DIV_W, default 8, width of the clock divider.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  in  1, cmd_ready  out  1: command handshake.
REQ-007 cmd_data  in  DATA_W  transmit word; cmd_cs  in  $clog2(NUM_CS) (min 1)  target select.
REQ-008 cmd_cpol, cmd_cpha  in  1 each  SPI mode; cmd_last  in  1  release CS after this word.
REQ-009 clk_div  in  DIV_W  half-period H = clk_div+1 cycles.
REQ-010 rsp_valid  out  1  one-cycle pulse; rsp_data  out  DATA_W  received word.
REQ-011 sck  out  1, sdo  out  1, sdi  in  1, csn  out  NUM_CS  active-low selects.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready high only in IDLE.
REQ-014 SHALL latch cmd_data, cmd_cs, mode, cmd_last and clk_div at acceptance; later input changes have no effect.
REQ-015 FSM states: IDLE, GAP, SETUP, SHIFT, HOLD.
REQ-016 Accept: if a CS is held and differs from cmd_cs -> GAP (all csn high, H cycles) -> SETUP; else -> SETUP.
REQ-017 SETUP: csn[cmd_cs] low, sck at CPOL, first bit driven on sdo, lasts H cycles.
REQ-018 SHIFT: 2*DATA_W sck toggles, one every H cycles; CPHA=0 samples sdi on leading edge, shifts sdo on trailing edge; CPHA=1 shifts on leading edge, samples on trailing edge.
REQ-019 HOLD: H cycles after last toggle, sck at CPOL; then rsp_valid=1 with rsp_data for one cycle, FSM -> IDLE.
REQ-020 rsp_valid SHALL assert exactly (2*DATA_W+2)*H cycles after the acceptance edge (no GAP); GAP adds H.
REQ-021 cmd_last=1: csn returns to all-high in the cycle rsp_valid asserts; cmd_last=0: selected csn stays low in IDLE.
REQ-022 Mode change on a held CS: sck moves to new CPOL at SETUP entry; CS not released.
REQ-023 cmd_cs >= NUM_CS: transfer runs with timing unchanged, no csn asserted, rsp_data still captured.
REQ-024 clk_div=0: sck toggles every cycle (sck = clk/2).
REQ-025 No response backpressure; rsp_data holds until next rsp_valid.
REQ-026 Bit order MSB first unless REQ-030 applies.

Reset
REQ-027 rst_n low: FSM IDLE, csn all ones, sck 0, sdo 0, rsp_valid 0, rsp_data 0, busy 0, cmd_ready 1 after release.
REQ-028 Reset mid-transfer SHALL abort without rsp_valid and release every CS immediately.

Configuration
REQ-029 Macro SPI_INITIATOR_CTRL_LSB_FIRST_EN.
REQ-030 Defined: adds input cmd_lsb_first (latched at acceptance), selecting LSB-first shift for both sdo and sdi; undefined: port absent, always MSB first.

Structure
REQ-031 Package spi_initiator_pkg SHALL hold the FSM state enum and a mode struct (cpol, cpha, last).
REQ-032 Sub-module spi_sck_gen SHALL hold the H-cycle divider counter and emit leading/trailing edge strobes plus sck.

Verification
REQ-033 DATA_W=8, sdi=sdo, mode 0, clk_div=0, 0xA5, cs=0, last=1 -> rsp_data=0xA5 exactly 18 cycles after accept, 8 sck rising edges, csn=4'b1111 after.
REQ-034 Mode 3, clk_div=3, 0x3C, sdi tied to a slave model returning 0xC3 -> sck idle high, 4-cycle half-periods, rsp_data=0xC3 at 72 cycles.
REQ-035 Two words cs=2, last=0 then last=1 -> csn[2] low throughout, no high glitch between words.
REQ-036 Held cs=1 (last=0), then cmd_cs=3 -> csn all high for H cycles before csn[3] low; rsp at (18+1)*H cycles.
REQ-037 rst_n low at cycle 7 of a transfer -> csn all high, sck 0, no rsp_valid; next command completes normally.
REQ-038 With SPI_INITIATOR_CTRL_LSB_FIRST_EN, cmd_lsb_first=1, 0x01 -> sdo high on first bit only, loopback rsp_data=0x01.
